// File: rtl/sha2_pkg.sv
// sha2_pkg: shared constants, FSM state type and round helpers for the
// variable-length SHA-224/SHA-256 hasher.
//   K            : the 64 SHA-256 round constants
//   IV256, IV224 : initial hash values for SHA-256 and SHA-224
//   state_t      : controller states
//   rightrotate, small_sigma0/1, sha256_round : pure combinational helpers
package sha2_pkg;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [0:7] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_UPDATE,
    ST_WRITE,
    ST_DONE
  } state_t;

  function automatic logic [31:0] rightrotate(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
  endfunction

  // One compression round; st and the result are packed {a,b,c,d,e,f,g,h}
  // with a in the most significant word.
  function automatic logic [255:0] sha256_round(input logic [255:0] st,
                                                input logic [31:0] kt,
                                                input logic [31:0] wt);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;
    {a, b, c, d, e, f, g, h} = st;
    t1 = h + (rightrotate(e, 6) ^ rightrotate(e, 11) ^ rightrotate(e, 25))
           + ((e & f) ^ (~e & g)) + kt + wt;
    t2 = (rightrotate(a, 2) ^ rightrotate(a, 13) ^ rightrotate(a, 22))
           + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

endpackage

// File: rtl/sha2_msg_sched.sv
// sha2_msg_sched: 16-word shift-window SHA-256 message scheduler.
//   clk, reset_n : clock, async active-low reset
//   load         : shift load_word in at the top of the window
//   shift        : shift the window and append the next expanded word
//   load_word    : message/padding word written while load=1
//   w_t          : schedule word for the current round (window bottom)
// After 16 loads the window holds W[0..15] with W[0] at the bottom; each
// shift then exposes W[t+1] and appends W[t+16].
module sha2_msg_sched
  import sha2_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] load_word,
  output logic [31:0] w_t
);

  logic [31:0] window [0:15];
  logic [31:0] w_next;

  // W[t+16] from the words currently at offsets 0, 1, 9 and 14.
  always_comb begin
    w_next = window[0] + small_sigma0(window[1]) + window[9] + small_sigma1(window[14]);
  end

  // Loading and expanding share one shift path; only the new top word differs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) window[i] <= '0;
    end else if (load || shift) begin
      for (int i = 0; i < 15; i++) window[i] <= window[i + 1];
      window[15] <= load ? load_word : w_next;
    end
  end

  assign w_t = window[0];

endmodule

// File: rtl/sha2_var_len_hasher.sv
// sha2_var_len_hasher: memory-mapped SHA-256 / SHA-224 engine with a runtime
// message length in 32-bit words; padding and block chaining in hardware.
//   clk, reset_n        : clock, async active-low reset
//   start               : job request, sampled only in IDLE
//   mode_224            : 1 = SHA-224 (7 digest words), 0 = SHA-256 (8 words)
//   len_words           : message length in words (0 = empty message)
//   message_addr        : word address of message word 0
//   output_addr         : word address of digest word 0
//   busy, done, err     : job status; err valid with done (length too large)
//   mem_clk, mem_we, mem_addr, mem_write_data, mem_read_data :
//                         shared synchronous word memory, 1-cycle read latency
module sha2_var_len_hasher
  import sha2_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode_224,
  input  logic [LEN_W-1:0] len_words,
  input  logic [15:0]      message_addr,
  input  logic [15:0]      output_addr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             mem_clk,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);

  localparam int GW = LEN_W + 5;

  state_t           state;
  logic             mode_q;
  logic [LEN_W-1:0] len_q;
  logic [15:0]      msg_addr_q;
  logic [15:0]      out_addr_q;
  logic [LEN_W:0]   blk;
  logic [4:0]       k;
  logic [5:0]       t;
  logic [2:0]       n;
  logic [255:0]     h_q;
  logic [255:0]     ws_q;

  logic [LEN_W:0]   len_plus;
  logic [LEN_W:0]   nb;
  logic             last_blk;
  logic [GW-1:0]    g_cap;
  logic [GW-1:0]    len_ext;
  logic [31:0]      pad_word;
  logic [255:0]     new_h;
  logic [31:0]      w_t;
  logic             sched_load;
  logic             sched_shift;

  assign mem_clk = clk;

  // Block count (L+18)>>4: room for the 0x80000000 marker and the two length words.
  assign len_plus = {1'b0, len_q} + (LEN_W + 1)'(18);
  assign nb       = len_plus >> 4;
  assign last_blk = (blk == nb - (LEN_W + 1)'(1));

  // Word address for padded word index idx of block b; padding slots reuse
  // the message base so every read stays inside the message window.
  function automatic logic [15:0] fetch_addr(input logic [LEN_W:0] b, input logic [4:0] idx,
                                             input logic [LEN_W-1:0] len, input logic [15:0] base);
    logic [GW-1:0] g;
    g = {b, 4'b0000} + GW'(idx);
    if (g < GW'(len)) return base + 16'(g);
    else              return base;
  endfunction

  function automatic logic [255:0] pack_iv(input logic m224);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*(7-i) +: 32] = m224 ? IV224[i] : IV256[i];
    return r;
  endfunction

  function automatic logic [31:0] word_sel(input logic [255:0] v, input logic [2:0] idx);
    return v[32*(3'd7 - idx) +: 32];
  endfunction

  // Padding mux for the word captured in LOAD cycle k (index k-1 of the block).
  always_comb begin
    g_cap    = {blk, 4'b0000} + GW'(k) - GW'(1);
    len_ext  = GW'(len_q);
    pad_word = '0;
    if (g_cap < len_ext)                 pad_word = mem_read_data;
    else if (g_cap == len_ext)           pad_word = 32'h8000_0000;
    else if (last_blk && k == 5'd16)     pad_word = 32'(len_q) << 5;
  end

  // Chained hash value after the current block.
  always_comb begin
    new_h = '0;
    for (int i = 0; i < 8; i++) new_h[32*i +: 32] = h_q[32*i +: 32] + ws_q[32*i +: 32];
  end

  assign sched_load  = (state == ST_LOAD) && (k != 5'd0);
  assign sched_shift = (state == ST_COMPUTE);

  sha2_msg_sched u_sched (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (sched_load),
    .shift     (sched_shift),
    .load_word (pad_word),
    .w_t       (w_t)
  );

  // Controller: memory-side outputs are registered on the transition into the
  // cycle where they apply, so the address for LOAD cycle k is already valid
  // during that cycle and its data is captured one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mode_q         <= 1'b0;
      len_q          <= '0;
      msg_addr_q     <= '0;
      out_addr_q     <= '0;
      blk            <= '0;
      k              <= '0;
      t              <= '0;
      n              <= '0;
      h_q            <= '0;
      ws_q           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          mem_we <= 1'b0;
          if (start) begin
            if ({1'b0, len_words} > (LEN_W + 1)'(MAX_WORDS)) begin
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              mode_q     <= mode_224;
              len_q      <= len_words;
              msg_addr_q <= message_addr;
              out_addr_q <= output_addr;
              h_q        <= pack_iv(mode_224);
              ws_q       <= pack_iv(mode_224);
              blk        <= '0;
              k          <= '0;
              mem_addr   <= fetch_addr('0, 5'd0, len_words, message_addr);
              busy       <= 1'b1;
              err        <= 1'b0;
              state      <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          k <= k + 5'd1;
          if (k < 5'd15) mem_addr <= fetch_addr(blk, k + 5'd1, len_q, msg_addr_q);
          if (k == 5'd16) begin
            t     <= '0;
            state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          ws_q <= sha256_round(ws_q, K[t], w_t);
          t    <= t + 6'd1;
          if (t == 6'd63) state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          h_q  <= new_h;
          ws_q <= new_h;
          if (blk + (LEN_W + 1)'(1) < nb) begin
            blk      <= blk + (LEN_W + 1)'(1);
            k        <= '0;
            mem_addr <= fetch_addr(blk + (LEN_W + 1)'(1), 5'd0, len_q, msg_addr_q);
            state    <= ST_LOAD;
          end else begin
            n              <= '0;
            mem_we         <= 1'b1;
            mem_addr       <= out_addr_q;
            mem_write_data <= new_h[255 -: 32];
            state          <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (n == (mode_q ? 3'd6 : 3'd7)) begin
            mem_we <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_DONE;
          end else begin
            n              <= n + 3'd1;
            mem_addr       <= out_addr_q + 16'(n + 3'd1);
            mem_write_data <= word_sel(h_q, n + 3'd1);
          end
        end
        ST_DONE: begin
          mem_we <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_var_len_hasher.sv
// tb_sha2_var_len_hasher: directed bench for sha2_var_len_hasher with a
// behavioural word memory and an independent software SHA-256/224 model.
module tb_sha2_var_len_hasher;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        mode_224;
  logic [15:0] len_words;
  logic [15:0] message_addr;
  logic [15:0] output_addr;
  logic        busy, done, err, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:65535];
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [31:0] bd_data;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [255:0] EMPTY256 = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] EMPTY224 = {224'hd14a028c2a3a2bc9476102bb288234c415a2b01f828ea62ac5b3e42f, 32'h0};
  localparam logic [255:0] ABC256   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] ABC224   = {224'h75388b16512776cc5dba5da1fd890150b0c6455cb4f58b1952522525, 32'h0};
  localparam logic [31:0]  SENT     = 32'hdeadbeef;

  localparam logic [31:0] TK [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] TIV256 [0:7] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] TIV224 [0:7] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  sha2_var_len_hasher #(.MAX_WORDS(64), .LEN_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .mode_224       (mode_224),
    .len_words      (len_words),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Synchronous word memory with a bench-side write port for preloading.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_write_data;
    if (bd_we)  mem[bd_addr]  <= bd_data;
    mem_read_data <= mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic memWrite(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
    return (x >> s) | (x << (32 - s));
  endfunction

  // Reference digest straight from FIPS 180-4, reading message words from mem.
  function automatic logic [255:0] sha_model(input logic m224, input int len, input logic [15:0] base);
    logic [31:0] hh [0:7];
    logic [31:0] w [0:63];
    logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, t1, t2, s0, s1;
    logic [255:0] r;
    int nblk, gi;
    nblk = (len * 32 + 65 + 511) / 512;
    for (int j = 0; j < 8; j++) hh[j] = m224 ? TIV224[j] : TIV256[j];
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 16; i++) begin
        gi = b * 16 + i;
        if (gi < len)                           w[i] = mem[16'(base + gi)];
        else if (gi == len)                     w[i] = 32'h8000_0000;
        else if (b == nblk - 1 && i == 15)      w[i] = 32'(len * 32);
        else                                    w[i] = 32'h0;
      end
      for (int i = 16; i < 64; i++) begin
        s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
        s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
        w[i] = w[i-16] + s0 + w[i-7] + s1;
      end
      va = hh[0]; vb = hh[1]; vc = hh[2]; vd = hh[3];
      ve = hh[4]; vf = hh[5]; vg = hh[6]; vh = hh[7];
      for (int i = 0; i < 64; i++) begin
        t1 = vh + (rotr(ve, 6) ^ rotr(ve, 11) ^ rotr(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + TK[i] + w[i];
        t2 = (rotr(va, 2) ^ rotr(va, 13) ^ rotr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
        vh = vg; vg = vf; vf = ve; ve = vd + t1;
        vd = vc; vc = vb; vb = va; va = t1 + t2;
      end
      hh[0] += va; hh[1] += vb; hh[2] += vc; hh[3] += vd;
      hh[4] += ve; hh[5] += vf; hh[6] += vg; hh[7] += vh;
    end
    r = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
    if (m224) r[31:0] = 32'h0;
    return r;
  endfunction

  function automatic logic [255:0] read_digest(input logic [15:0] oaddr, input int words);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < words; i++) r[32*(7-i) +: 32] = mem[16'(oaddr + i)];
    return r;
  endfunction

  // Runs one job: pulses start, scrambles the inputs right after they are
  // sampled, then counts cycles, write strobes and out-of-window reads.
  task automatic applyStimulus(input logic m224, input int len, input logic [15:0] maddr,
                               input logic [15:0] oaddr, input logic poke_start,
                               output int cyc, output int we_cnt, output int rd_bad,
                               output logic err_at_done);
    logic finished;
    cyc = 0; we_cnt = 0; rd_bad = 0; err_at_done = 1'b0; finished = 1'b0;
    @(negedge clk);
    start = 1'b1; mode_224 = m224; len_words = 16'(len);
    message_addr = maddr; output_addr = oaddr;
    @(posedge clk);
    #1;
    start = 1'b0; mode_224 = ~m224; len_words = 16'd3;
    message_addr = maddr ^ 16'h5555; output_addr = oaddr ^ 16'h00f0;
    while (!finished) begin
      @(negedge clk);
      cyc++;
      start = poke_start && (cyc == 40);
      if (mem_we) we_cnt++;
      else if (busy && len > 0 && (16'(mem_addr - maddr) >= 16'(len))) rd_bad++;
      if (done) begin
        finished    = 1'b1;
        err_at_done = err;
      end else if (cyc >= 2000) begin
        checkOutput("done_timeout", {255'd0, done}, 256'd1);
        finished = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc, wec, rdb;
    logic e;
    logic [255:0] exp_d;

    reset_n = 1'b0; start = 1'b0; mode_224 = 1'b0; len_words = '0;
    message_addr = '0; output_addr = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy",  {255'd0, busy},   256'd0);
    checkOutput("rst_done",  {255'd0, done},   256'd0);
    checkOutput("rst_err",   {255'd0, err},    256'd0);
    checkOutput("rst_we",    {255'd0, mem_we}, 256'd0);
    checkOutput("rst_addr",  {240'd0, mem_addr}, 256'd0);
    checkOutput("rst_wdata", {224'd0, mem_write_data}, 256'd0);
    reset_n = 1'b1;
    $display("[TB] reset released");

    for (int i = 0; i < 13; i++) memWrite(16'(16'hfff8 + i), $urandom);
    for (int i = 0; i < 20; i++) memWrite(16'(16'h0100 + i), $urandom);
    for (int i = 0; i < 64; i++) memWrite(16'(16'h0200 + i), $urandom);
    for (int i = 0; i < 14; i++) memWrite(16'(16'h0300 + i),
                                          {8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)});
    memWrite(16'h1017, SENT);
    for (int i = 0; i < 8; i++) memWrite(16'(16'h1040 + i), SENT);

    // Empty message, SHA-256.
    applyStimulus(1'b0, 0, 16'h0000, 16'h1000, 1'b0, cyc, wec, rdb, e);
    checkOutput("empty256_digest",  read_digest(16'h1000, 8), EMPTY256);
    checkOutput("empty256_latency", 256'(cyc), 256'd91);
    checkOutput("empty256_writes",  256'(wec), 256'd8);
    checkOutput("empty256_err",     {255'd0, e}, 256'd0);

    // Empty message, SHA-224: seven words, eighth slot untouched.
    applyStimulus(1'b1, 0, 16'h0000, 16'h1010, 1'b0, cyc, wec, rdb, e);
    checkOutput("empty224_digest",  read_digest(16'h1010, 7), EMPTY224);
    checkOutput("empty224_latency", 256'(cyc), 256'd90);
    checkOutput("empty224_writes",  256'(wec), 256'd7);
    checkOutput("empty224_word7",   {224'd0, mem[16'h1017]}, {224'd0, SENT});

    // 14-word FIPS vector "abcdbcde...nopq": two blocks.
    applyStimulus(1'b0, 14, 16'h0300, 16'h1020, 1'b0, cyc, wec, rdb, e);
    checkOutput("abc256_digest",  read_digest(16'h1020, 8), ABC256);
    checkOutput("abc256_latency", 256'(cyc), 256'd173);
    checkOutput("abc256_reads",   256'(rdb), 256'd0);
    applyStimulus(1'b1, 14, 16'h0300, 16'h1030, 1'b0, cyc, wec, rdb, e);
    checkOutput("abc224_digest",  read_digest(16'h1030, 7), ABC224);
    checkOutput("abc224_latency", 256'(cyc), 256'd172);

    // 13 words across the address wrap, one block; a start while busy is ignored.
    exp_d = sha_model(1'b0, 13, 16'hfff8);
    applyStimulus(1'b0, 13, 16'hfff8, 16'h1050, 1'b1, cyc, wec, rdb, e);
    checkOutput("l13_digest",  read_digest(16'h1050, 8), exp_d);
    checkOutput("l13_latency", 256'(cyc), 256'd91);
    checkOutput("l13_reads",   256'(rdb), 256'd0);

    // 20 words, two blocks; reads confined to the message window.
    exp_d = sha_model(1'b0, 20, 16'h0100);
    applyStimulus(1'b0, 20, 16'h0100, 16'h1060, 1'b0, cyc, wec, rdb, e);
    checkOutput("l20_digest",  read_digest(16'h1060, 8), exp_d);
    checkOutput("l20_latency", 256'(cyc), 256'd173);
    checkOutput("l20_reads",   256'(rdb), 256'd0);

    // Largest accepted length, five blocks.
    exp_d = sha_model(1'b0, 64, 16'h0200);
    applyStimulus(1'b0, 64, 16'h0200, 16'h1070, 1'b0, cyc, wec, rdb, e);
    checkOutput("l64_digest",  read_digest(16'h1070, 8), exp_d);
    checkOutput("l64_latency", 256'(cyc), 256'd419);
    checkOutput("l64_err",     {255'd0, e}, 256'd0);

    // Over-length request: immediate done with err, memory untouched.
    applyStimulus(1'b0, 65, 16'h0200, 16'h1040, 1'b0, cyc, wec, rdb, e);
    checkOutput("l65_err",     {255'd0, e}, 256'd1);
    checkOutput("l65_latency", 256'(cyc), 256'd1);
    checkOutput("l65_writes",  256'(wec), 256'd0);
    checkOutput("l65_memory",  read_digest(16'h1040, 8), {8{SENT}});

    // Reset during block 1 compute, then a fresh empty-message job.
    @(negedge clk);
    start = 1'b1; mode_224 = 1'b0; len_words = 16'd20;
    message_addr = 16'h0100; output_addr = 16'h1080;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (120) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_busy_before", {255'd0, busy}, 256'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {255'd0, busy},     256'd0);
    checkOutput("mid_rst_we",   {255'd0, mem_we},   256'd0);
    checkOutput("mid_rst_addr", {240'd0, mem_addr}, 256'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b0, 0, 16'h0000, 16'h1080, 1'b0, cyc, wec, rdb, e);
    checkOutput("post_rst_digest",  read_digest(16'h1080, 8), EMPTY256);
    checkOutput("post_rst_latency", 256'(cyc), 256'd91);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
